// File: rtl/vga_pkg.sv
// Shared VGA bus widths, active-area defaults and motion direction type.
package vga_pkg;

   localparam int unsigned H_ACTIVE = 800;
   localparam int unsigned V_ACTIVE = 600;
   localparam int unsigned CNT_W    = 11;
   localparam int unsigned RGB_W    = 12;
   localparam int unsigned BND_W    = 12;

   typedef enum logic {
      MOVE_POS = 1'b0,
      MOVE_NEG = 1'b1
   } dir_t;

   typedef struct packed {
      logic [CNT_W-1:0] hcount;
      logic             hsync;
      logic             hblnk;
      logic [CNT_W-1:0] vcount;
      logic             vsync;
      logic             vblnk;
      logic [RGB_W-1:0] rgb;
   } vga_sig_t;

endpackage

// File: rtl/vga_if.sv
// VGA bus between drawing stages: timing counters, sync/blank flags and colour.
interface vga_if;
   import vga_pkg::*;

   logic [CNT_W-1:0] hcount;
   logic             hsync;
   logic             hblnk;
   logic [CNT_W-1:0] vcount;
   logic             vsync;
   logic             vblnk;
   logic [RGB_W-1:0] rgb;

   modport in  (input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
   modport out (output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
endinterface

// File: rtl/rect_motion.sv
// Per-frame rectangle motion: vblank-edge tick, two-axis bounce FSM, bounce pulse.
module rect_motion
   import vga_pkg::*;
#(
   parameter int unsigned H_ACT  = H_ACTIVE,
   parameter int unsigned V_ACT  = V_ACTIVE,
   parameter int unsigned RECT_W = 64,
   parameter int unsigned RECT_H = 48,
   parameter int unsigned X_INIT = 100,
   parameter int unsigned Y_INIT = 50,
   parameter int unsigned SPEED  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_vblnk,
   input  logic             i_enable,
   output logic             o_bounce,
   output logic [CNT_W-1:0] o_pos_x,
   output logic [CNT_W-1:0] o_pos_y
);

   if ((X_INIT + RECT_W > H_ACT) || (Y_INIT + RECT_H > V_ACT)) begin : g_illegal
      $fatal(1, "rect_motion: initial rectangle does not fit the active area");
   end

   localparam int unsigned X_MAX = H_ACT - RECT_W;
   localparam int unsigned Y_MAX = V_ACT - RECT_H;

   logic             r_vblnk_prev;
   logic             r_bounce;
   dir_t             r_dir_x;
   dir_t             r_dir_y;
   logic [CNT_W-1:0] r_pos_x;
   logic [CNT_W-1:0] r_pos_y;

   logic             w_step;
   logic [BND_W-1:0] w_px;
   logic [BND_W-1:0] w_py;
   logic             w_x_over;
   logic             w_x_under;
   logic             w_y_over;
   logic             w_y_under;
   logic             w_x_refl;
   logic             w_y_refl;

   // Reflection conditions evaluated 12 bits wide so the far-edge sum cannot wrap
   assign w_step    = i_vblnk & ~r_vblnk_prev & i_enable;
   assign w_px      = BND_W'(r_pos_x);
   assign w_py      = BND_W'(r_pos_y);
   assign w_x_over  = (w_px + BND_W'(SPEED) + BND_W'(RECT_W)) > BND_W'(H_ACT);
   assign w_x_under = w_px < BND_W'(SPEED);
   assign w_y_over  = (w_py + BND_W'(SPEED) + BND_W'(RECT_H)) > BND_W'(V_ACT);
   assign w_y_under = w_py < BND_W'(SPEED);
   assign w_x_refl  = (r_dir_x == MOVE_POS) ? w_x_over : w_x_under;
   assign w_y_refl  = (r_dir_y == MOVE_POS) ? w_y_over : w_y_under;

   // Position/direction FSM; registers move only on an enabled vblank rising edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vblnk_prev <= 1'b1;
         r_bounce     <= 1'b0;
         r_dir_x      <= MOVE_POS;
         r_dir_y      <= MOVE_POS;
         r_pos_x      <= CNT_W'(X_INIT);
         r_pos_y      <= CNT_W'(Y_INIT);
      end else begin
         r_vblnk_prev <= i_vblnk;
         r_bounce     <= w_step & (w_x_refl | w_y_refl);
         if (w_step) begin
            case (r_dir_x)
               MOVE_POS: begin
                  if (w_x_over) begin
                     r_pos_x <= CNT_W'(X_MAX);
                     r_dir_x <= MOVE_NEG;
                  end else begin
                     r_pos_x <= r_pos_x + CNT_W'(SPEED);
                  end
               end
               MOVE_NEG: begin
                  if (w_x_under) begin
                     r_pos_x <= '0;
                     r_dir_x <= MOVE_POS;
                  end else begin
                     r_pos_x <= r_pos_x - CNT_W'(SPEED);
                  end
               end
               default: r_dir_x <= MOVE_POS;
            endcase
            case (r_dir_y)
               MOVE_POS: begin
                  if (w_y_over) begin
                     r_pos_y <= CNT_W'(Y_MAX);
                     r_dir_y <= MOVE_NEG;
                  end else begin
                     r_pos_y <= r_pos_y + CNT_W'(SPEED);
                  end
               end
               MOVE_NEG: begin
                  if (w_y_under) begin
                     r_pos_y <= '0;
                     r_dir_y <= MOVE_POS;
                  end else begin
                     r_pos_y <= r_pos_y - CNT_W'(SPEED);
                  end
               end
               default: r_dir_y <= MOVE_POS;
            endcase
         end
      end
   end

   assign o_bounce = r_bounce;
   assign o_pos_x  = r_pos_x;
   assign o_pos_y  = r_pos_y;

endmodule

// File: rtl/draw_rect_bounce.sv
// Two-stage VGA overlay stage drawing a self-moving, edge-bouncing solid rectangle.
module draw_rect_bounce
   import vga_pkg::*;
#(
   parameter int unsigned      H_ACTIVE   = vga_pkg::H_ACTIVE,
   parameter int unsigned      V_ACTIVE   = vga_pkg::V_ACTIVE,
   parameter int unsigned      RECT_W     = 64,
   parameter int unsigned      RECT_H     = 48,
   parameter logic [RGB_W-1:0] RECT_COLOR = 12'hF80,
   parameter int unsigned      X_INIT     = 100,
   parameter int unsigned      Y_INIT     = 50,
   parameter int unsigned      SPEED      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   vga_if.in                in,
   vga_if.out               out,
   input  logic             enable,
   output logic             bounce,
   output logic [CNT_W-1:0] pos_x,
   output logic [CNT_W-1:0] pos_y
);

   logic [CNT_W-1:0] w_pos_x;
   logic [CNT_W-1:0] w_pos_y;
   logic [BND_W-1:0] w_hc;
   logic [BND_W-1:0] w_vc;
   logic [BND_W-1:0] w_x0;
   logic [BND_W-1:0] w_x1;
   logic [BND_W-1:0] w_y0;
   logic [BND_W-1:0] w_y1;
   logic             w_hit;
   vga_sig_t         w_s1;
   vga_sig_t         w_s2;
   vga_sig_t         r_s1;
   vga_sig_t         r_s2;
   logic             r_hit;

   rect_motion #(
      .H_ACT  (H_ACTIVE),
      .V_ACT  (V_ACTIVE),
      .RECT_W (RECT_W),
      .RECT_H (RECT_H),
      .X_INIT (X_INIT),
      .Y_INIT (Y_INIT),
      .SPEED  (SPEED)
   ) u_motion (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_vblnk  (in.vblnk),
      .i_enable (enable),
      .o_bounce (bounce),
      .o_pos_x  (w_pos_x),
      .o_pos_y  (w_pos_y)
   );

   // Rectangle membership of the incoming pixel, only inside the active area
   assign w_hc  = BND_W'(in.hcount);
   assign w_vc  = BND_W'(in.vcount);
   assign w_x0  = BND_W'(w_pos_x);
   assign w_y0  = BND_W'(w_pos_y);
   assign w_x1  = w_x0 + BND_W'(RECT_W);
   assign w_y1  = w_y0 + BND_W'(RECT_H);
   assign w_hit = (w_hc >= w_x0) & (w_hc < w_x1) & (w_vc >= w_y0) & (w_vc < w_y1)
                & ~in.hblnk & ~in.vblnk;

   assign w_s1 = '{hcount: in.hcount, hsync: in.hsync, hblnk: in.hblnk,
                   vcount: in.vcount, vsync: in.vsync, vblnk: in.vblnk, rgb: in.rgb};

   // Second stage keeps timing, substitutes fill colour on a hit
   always_comb begin
      w_s2     = r_s1;
      w_s2.rgb = r_hit ? RECT_COLOR : r_s1.rgb;
   end

   // Two-deep pixel pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1  <= '0;
         r_hit <= 1'b0;
         r_s2  <= '0;
      end else begin
         r_s1  <= w_s1;
         r_hit <= w_hit;
         r_s2  <= w_s2;
      end
   end

   assign out.hcount = r_s2.hcount;
   assign out.hsync  = r_s2.hsync;
   assign out.hblnk  = r_s2.hblnk;
   assign out.vcount = r_s2.vcount;
   assign out.vsync  = r_s2.vsync;
   assign out.vblnk  = r_s2.vblnk;
   assign out.rgb    = r_s2.rgb;
   assign pos_x      = w_pos_x;
   assign pos_y      = w_pos_y;

endmodule

// File: tb/tb_draw_rect_bounce.sv
// Bench for draw_rect_bounce: three placements (default, right edge, corner) share one input bus.
module tb_draw_rect_bounce;

   localparam int HA = 800;
   localparam int VA = 600;
   localparam int RW = 64;
   localparam int RH = 48;
   localparam int SP = 4;
   localparam logic [11:0] FILL = 12'hF80;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable;
   logic        w_bnc [3];
   logic [10:0] w_px  [3];
   logic [10:0] w_py  [3];
   logic [37:0] w_obs [3];

   vga_if vin ();
   vga_if vo0 ();
   vga_if vo1 ();
   vga_if vo2 ();

   draw_rect_bounce u_dut0 (
      .clk(clk), .rst_n(rst_n), .in(vin), .out(vo0), .enable(enable),
      .bounce(w_bnc[0]), .pos_x(w_px[0]), .pos_y(w_py[0]));

   draw_rect_bounce #(.X_INIT(734)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in(vin), .out(vo1), .enable(enable),
      .bounce(w_bnc[1]), .pos_x(w_px[1]), .pos_y(w_py[1]));

   draw_rect_bounce #(.X_INIT(734), .Y_INIT(550)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in(vin), .out(vo2), .enable(enable),
      .bounce(w_bnc[2]), .pos_x(w_px[2]), .pos_y(w_py[2]));

   assign w_obs[0] = {vo0.hcount, vo0.hsync, vo0.hblnk, vo0.vcount, vo0.vsync, vo0.vblnk, vo0.rgb};
   assign w_obs[1] = {vo1.hcount, vo1.hsync, vo1.hblnk, vo1.vcount, vo1.vsync, vo1.vblnk, vo1.rgb};
   assign w_obs[2] = {vo2.hcount, vo2.hsync, vo2.hblnk, vo2.vcount, vo2.vsync, vo2.vblnk, vo2.rgb};

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int          ix [3] = '{100, 734, 734};
   int          iy [3] = '{50, 50, 550};
   int          mx [3];
   int          my [3];
   int          mdx[3];
   int          mdy[3];
   bit          m_prev;
   logic [37:0] q  [3][$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one axis moved by SPEED in direction d, reflected back into [0, act-ext]
   function automatic void move_axis(input int p, input int d, input int ext, input int act,
                                     output int np, output int nd, output bit b);
      np = p + d * SP;
      nd = d;
      b  = 1'b0;
      if (np + ext > act) begin
         np = act - ext; nd = -1; b = 1'b1;
      end else if (np < 0) begin
         np = 0; nd = 1; b = 1'b1;
      end
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mx[i] = ix[i]; my[i] = iy[i]; mdx[i] = 1; mdy[i] = 1;
         q[i].delete();
         q[i].push_back(38'd0);
      end
      m_prev = 1'b1;
   endtask

   // drive one pixel clock, predict the outputs and compare after the edge
   task automatic step(input int hc, input bit hs, input bit hb, input int vc, input bit vs,
                       input bit vb, input logic [11:0] rgb, input bit en);
      bit          tick;
      bit          hit;
      bit          bx, by;
      bit          eb[3];
      int          nx, ndx, ny, ndy;
      logic [11:0] er;
      logic [37:0] rec;
      vin.hcount = 11'(hc); vin.hsync = hs; vin.hblnk = hb;
      vin.vcount = 11'(vc); vin.vsync = vs; vin.vblnk = vb;
      vin.rgb    = rgb;     enable    = en;
      tick   = vb && !m_prev;
      m_prev = vb;
      for (int i = 0; i < 3; i++) begin
         hit = (hc >= mx[i]) && (hc < mx[i] + RW) && (vc >= my[i]) && (vc < my[i] + RH) && !hb && !vb;
         er  = hit ? FILL : rgb;
         q[i].push_back({11'(hc), hs, hb, 11'(vc), vs, vb, er});
         eb[i] = 1'b0;
         if (tick && en) begin
            move_axis(mx[i], mdx[i], RW, HA, nx, ndx, bx);
            move_axis(my[i], mdy[i], RH, VA, ny, ndy, by);
            mx[i] = nx; mdx[i] = ndx; my[i] = ny; mdy[i] = ndy;
            eb[i] = bx | by;
         end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         rec = q[i].pop_front();
         chk($sformatf("out_bus%0d", i), 64'(w_obs[i]), 64'(rec));
         chk($sformatf("pos_x%0d", i), 64'(w_px[i]), 64'(mx[i]));
         chk($sformatf("pos_y%0d", i), 64'(w_py[i]), 64'(my[i]));
         chk($sformatf("bounce%0d", i), 64'(w_bnc[i]), 64'(eb[i]));
      end
   endtask

   task automatic frame_edge(input bit en);
      step(0, 0, 1, 600, 0, 0, 12'h000, en);
      step(0, 0, 1, 600, 1, 1, 12'h000, en);
   endtask

   initial begin
      int hc, vc;
      bit en;
      vin.hcount = '0; vin.hsync = 1'b0; vin.hblnk = 1'b0;
      vin.vcount = '0; vin.vsync = 1'b0; vin.vblnk = 1'b0;
      vin.rgb    = '0; enable    = 1'b1;

      // reset values
      #1 rst_n = 1'b0;
      #2;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_out%0d", i), 64'(w_obs[i]), 64'd0);
         chk($sformatf("rst_px%0d", i), 64'(w_px[i]), 64'(ix[i]));
         chk($sformatf("rst_py%0d", i), 64'(w_py[i]), 64'(iy[i]));
         chk($sformatf("rst_bnc%0d", i), 64'(w_bnc[i]), 64'd0);
      end
      model_reset();
      @(posedge clk); #1 rst_n = 1'b1;

      // overlay hit, right-boundary miss, blanking pass-through
      step(100, 0, 0, 50, 0, 0, 12'h000, 1);
      step(164, 0, 0, 50, 0, 0, 12'h0AB, 1);
      chk("hit_rgb", 64'(w_obs[0][11:0]), 64'(FILL));
      step(120, 1, 1, 60, 1, 0, 12'h123, 1);
      chk("edge_miss_rgb", 64'(w_obs[0][11:0]), 64'h0AB);
      step(0, 0, 0, 0, 0, 0, 12'h000, 1);
      chk("blank_rgb", 64'(w_obs[0][11:0]), 64'h123);
      chk("blank_hcount", 64'(vo0.hcount), 64'd120);
      chk("blank_hblnk", 64'(vo0.hblnk), 64'd1);
      step(0, 0, 0, 0, 0, 0, 12'h000, 1);

      // first frame tick: plain step, right-edge bounce, corner bounce
      step(0, 0, 1, 600, 1, 1, 12'h000, 1);
      chk("tick_x0", 64'(w_px[0]), 64'd104);
      chk("tick_y0", 64'(w_py[0]), 64'd54);
      chk("redge_x1", 64'(w_px[1]), 64'd736);
      chk("redge_bnc1", 64'(w_bnc[1]), 64'd1);
      chk("corner_x2", 64'(w_px[2]), 64'd736);
      chk("corner_y2", 64'(w_py[2]), 64'd552);
      chk("corner_bnc2", 64'(w_bnc[2]), 64'd1);
      step(0, 0, 1, 601, 0, 1, 12'h000, 1);
      chk("corner_pulse_end", 64'(w_bnc[2]), 64'd0);
      for (int k = 0; k < 99; k++) step(0, 0, 1, 602, 0, 1, 12'h000, 1);
      chk("hold_x0", 64'(w_px[0]), 64'd104);
      chk("hold_y0", 64'(w_py[0]), 64'd54);

      // second tick moves away from the reflected edges
      frame_edge(1);
      chk("redge2_x1", 64'(w_px[1]), 64'd732);
      chk("corner2_x2", 64'(w_px[2]), 64'd732);
      chk("corner2_y2", 64'(w_py[2]), 64'd548);

      // freeze for three frames
      for (int f = 0; f < 3; f++) frame_edge(0);
      chk("freeze_x0", 64'(w_px[0]), 64'd108);
      chk("freeze_y0", 64'(w_py[0]), 64'd58);

      // randomized frames against the model
      for (int f = 0; f < 40; f++) begin
         for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 1) == 1) begin
               hc = mx[0] + int'($urandom_range(0, RW + 16)) - 8;
               vc = my[0] + int'($urandom_range(0, RH + 16)) - 8;
               if (hc < 0) hc = 0;
               if (vc < 0) vc = 0;
            end else begin
               hc = int'($urandom_range(0, 1055));
               vc = int'($urandom_range(0, 599));
            end
            step(hc, 1'($urandom), hc >= HA, vc, 1'($urandom), 0, 12'($urandom), 1'($urandom));
         end
         en = ($urandom_range(0, 3) != 0);
         step(0, 0, 1, 600, 0, 0, 12'h000, en);
         for (int k = 0; k < 3; k++) step(0, 0, 1, 600 + k, 1, 1, 12'($urandom), en);
      end

      // asynchronous reset mid-line, released while vblank is high
      step(110, 1, 0, 60, 1, 0, 12'hABC, 1);
      step(111, 1, 0, 61, 1, 0, 12'hABD, 1);
      #3 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("midrst_out%0d", i), 64'(w_obs[i]), 64'd0);
         chk($sformatf("midrst_px%0d", i), 64'(w_px[i]), 64'(ix[i]));
      end
      vin.vblnk = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      for (int k = 0; k < 5; k++) step(0, 0, 1, 600, 0, 1, 12'h000, 1);
      chk("rel_vblank_x0", 64'(w_px[0]), 64'd100);
      chk("rel_vblank_y0", 64'(w_py[0]), 64'd50);
      frame_edge(1);
      chk("rel_tick_x0", 64'(w_px[0]), 64'd104);
      chk("rel_tick_y0", 64'(w_py[0]), 64'd54);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
